// File: rtl/data_memory_ctrl.sv
// Byte-addressable RV32 data memory with sub-word access, fixed access latency
// and a busywait stall; a post-reset sweep zeroes the array before use.
//
// state | meaning
// INIT  | clearing word clr_ptr each cycle, pipeline stalled
// IDLE  | waiting for a request (LATENCY=0 executes here)
// WAIT  | latency countdown on captured request, executes when cnt=0
// RESP  | one-cycle response slot, requests ignored
module data_memory_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  read,
  input  logic [2:0]  write,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busywait,
  output logic        misaligned,
  output logic [31:0] DEBUG_DATA
);

  localparam int WORDS = (2 ** ADDR_WIDTH) / 4;
  localparam int IW = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;
  localparam logic [IW-1:0] LAST_WORD = IW'(WORDS - 1);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

  state_t state, next_state;
  logic [IW-1:0] clr_ptr;
  logic [3:0] cnt, cnt_next;
  logic capture, do_access, valid;

  logic [3:0] cap_read;
  logic [2:0] cap_write;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [31:0] cap_data;

  logic [3:0] acc_read;
  logic [2:0] acc_write;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [31:0] acc_data;
  logic [IW-1:0] widx;
  logic [1:0] lane;

  logic [31:0] mem [WORDS];
  logic [31:0] word, shifted, load_val, wlane;
  logic [3:0] be;
  logic load_mis, st_mis, acc_mis, is_read, mem_we;
  logic unused_bits;

  assign unused_bits = ^address[31:ADDR_WIDTH];
  assign valid = read[3] ^ write[2];
  assign DEBUG_DATA = mem[0];

  // In WAIT the captured request is executed; live inputs are ignored.
  always_comb begin
    acc_read  = read;
    acc_write = write;
    acc_addr  = address[ADDR_WIDTH-1:0];
    acc_data  = writedata;
    if (state == WAIT) begin
      acc_read  = cap_read;
      acc_write = cap_write;
      acc_addr  = cap_addr;
      acc_data  = cap_data;
    end
  end

  assign widx = IW'(acc_addr >> 2);
  assign lane = acc_addr[1:0];
  assign word = mem[widx];
  assign shifted = word >> {lane, 3'b000};
  assign wlane = acc_data << {lane, 3'b000};
  assign is_read = acc_read[3];

  always_comb begin
    load_val = '0;
    load_mis = 1'b0;
    case (acc_read[2:0])
      3'b000: load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100: load_val = {24'b0, shifted[7:0]};
      3'b001: begin
        load_mis = lane[0];
        load_val = {{16{shifted[15]}}, shifted[15:0]};
      end
      3'b101: begin
        load_mis = lane[0];
        load_val = {16'b0, shifted[15:0]};
      end
      3'b010: begin
        load_mis = |lane;
        load_val = word;
      end
      default: ;
    endcase
  end

  always_comb begin
    be     = '0;
    st_mis = 1'b0;
    case (acc_write[1:0])
      2'b00: be = 4'b0001 << lane;
      2'b01: begin
        st_mis = lane[0];
        be     = 4'b0011 << lane;
      end
      2'b10: begin
        st_mis = |lane;
        be     = 4'b1111;
      end
      default: ;
    endcase
  end

  assign acc_mis = is_read ? load_mis : st_mis;
  assign mem_we  = do_access & ~is_read & ~st_mis & ~reset;

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    do_access  = 1'b0;
    busywait   = 1'b0;
    case (state)
      INIT: begin
        busywait = 1'b1;
        if (clr_ptr == LAST_WORD) next_state = IDLE;
      end
      IDLE: begin
        if (valid) begin
          if (LATENCY == 0) begin
            do_access = 1'b1;
          end else if (LATENCY == 1) begin
            busywait   = 1'b1;
            do_access  = 1'b1;
            next_state = RESP;
          end else begin
            busywait   = 1'b1;
            capture    = 1'b1;
            cnt_next   = CNT_INIT;
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        busywait = 1'b1;
        if (cnt == 4'd0) begin
          do_access  = 1'b1;
          next_state = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: next_state = IDLE;
      default: next_state = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= INIT;
      clr_ptr    <= '0;
      cnt        <= '0;
      readdata   <= '0;
      misaligned <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (state == INIT) clr_ptr <= clr_ptr + IW'(1);
      if (do_access) begin
        misaligned <= acc_mis;
        if (acc_mis) readdata <= '0;
        else if (is_read) readdata <= load_val;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (capture) begin
      cap_read  <= read;
      cap_write <= write;
      cap_addr  <= address[ADDR_WIDTH-1:0];
      cap_data  <= writedata;
    end
  end

  always_ff @(posedge clock) begin
    if (state == INIT) begin
      mem[clr_ptr] <= '0;
    end else if (mem_we) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) mem[widx][8*k +: 8] <= wlane[8*k +: 8];
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: a byte-array reference model checked every cycle,
// plus literal expectations from hand-worked access sequences.
module tb_data_memory_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst2, rst0;
  logic [3:0] rd2, rd0;
  logic [2:0] wr2, wr0;
  logic [31:0] ad2, ad0, wd2, wd0;
  logic [31:0] q2, q0, dbg2, dbg0;
  logic bw2, bw0, mis2, mis0;

  data_memory_ctrl #(.ADDR_WIDTH(10), .LATENCY(2)) u_l2 (
    .clock(clock), .reset(rst2), .read(rd2), .write(wr2), .address(ad2),
    .writedata(wd2), .readdata(q2), .busywait(bw2), .misaligned(mis2),
    .DEBUG_DATA(dbg2));

  data_memory_ctrl #(.ADDR_WIDTH(6), .LATENCY(0)) u_l0 (
    .clock(clock), .reset(rst0), .read(rd0), .write(wr0), .address(ad0),
    .writedata(wd0), .readdata(q0), .busywait(bw0), .misaligned(mis0),
    .DEBUG_DATA(dbg0));

  logic [7:0] m2 [1024];
  logic [7:0] m0 [64];
  logic [31:0] e2_rd, e0_rd;
  logic e2_mis, e0_mis, e2_busy, e0_busy;
  bit en2 = 0, en0 = 0;
  int n_chk = 0, n_pass = 0;
  int c2, c0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [7:0] gb(int w, int a);
    return (w != 0) ? m0[a % 64] : m2[a % 1024];
  endfunction

  task automatic sbyte(int w, int a, logic [7:0] v);
    if (w != 0) m0[a % 64] = v;
    else m2[a % 1024] = v;
  endtask

  // Reference: the access the spec describes, applied to a flat byte array.
  task automatic model(int w, logic [3:0] r, logic [2:0] wr, logic [31:0] addr,
                       logic [31:0] wd);
    int depth, a, n;
    logic [31:0] v, nrd;
    logic nmis;
    depth = (w != 0) ? 64 : 1024;
    a = int'(addr[9:0]) % depth;
    if (r[3] == wr[2]) return;
    nrd  = (w != 0) ? e0_rd : e2_rd;
    nmis = 1'b0;
    if (r[3]) begin
      case (r[2:0])
        3'b000, 3'b100: n = 1;
        3'b001, 3'b101: n = 2;
        3'b010:         n = 4;
        default:        n = 0;
      endcase
      if (n == 0) nrd = 0;
      else if (a % n != 0) begin
        nmis = 1'b1;
        nrd  = 0;
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(gb(w, a + i)) << (8 * i));
        if (!r[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        nrd = v;
      end
    end else begin
      case (wr[1:0])
        2'b00: n = 1;
        2'b01: n = 2;
        2'b10: n = 4;
        default: n = 0;
      endcase
      if (n != 0) begin
        if (a % n != 0) begin
          nmis = 1'b1;
          nrd  = 0;
        end else begin
          for (int i = 0; i < n; i++) sbyte(w, a + i, 8'(wd >> (8 * i)));
        end
      end
    end
    if (w != 0) begin e0_rd = nrd; e0_mis = nmis; end
    else begin e2_rd = nrd; e2_mis = nmis; end
  endtask

  task automatic reset_model(int w);
    if (w != 0) begin
      for (int i = 0; i < 64; i++) m0[i] = 8'h00;
      e0_rd = 0; e0_mis = 0; e0_busy = 0;
    end else begin
      for (int i = 0; i < 1024; i++) m2[i] = 8'h00;
      e2_rd = 0; e2_mis = 0; e2_busy = 0;
    end
  endtask

  always @(negedge clock) begin
    if (en2) begin
      check("l2_busywait", 32'(bw2), 32'(e2_busy));
      check("l2_readdata", q2, e2_rd);
      check("l2_misaligned", 32'(mis2), 32'(e2_mis));
      check("l2_debug", dbg2, {gb(0, 3), gb(0, 2), gb(0, 1), gb(0, 0)});
    end
    if (en0) begin
      check("l0_busywait", 32'(bw0), 32'(e0_busy));
      check("l0_readdata", q0, e0_rd);
      check("l0_misaligned", 32'(mis0), 32'(e0_mis));
      check("l0_debug", dbg0, {gb(1, 3), gb(1, 2), gb(1, 1), gb(1, 0)});
    end
  end

  // Counts stalled cycles of the post-reset sweep, bounded.
  task automatic sweep(int w, output int cnt);
    cnt = 0;
    while (cnt < 2000) begin
      @(negedge clock);
      if (((w != 0) ? bw0 : bw2) == 1'b0) break;
      cnt++;
    end
  endtask

  // One LATENCY=2 access; returns in the RESP cycle with the request still held.
  task automatic acc2(logic [3:0] r, logic [2:0] wr, logic [31:0] a, logic [31:0] d);
    @(posedge clock); #1;
    rd2 = r; wr2 = wr; ad2 = a; wd2 = d; e2_busy = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    model(0, r, wr, a, d);
    e2_busy = 1'b0;
  endtask

  task automatic idle2();
    @(posedge clock); #1;
    rd2 = 0; wr2 = 0;
  endtask

  task automatic step0(logic [3:0] pr, logic [2:0] pw, logic [31:0] pa, logic [31:0] pd,
                       logic [3:0] r, logic [2:0] wr, logic [31:0] a, logic [31:0] d);
    @(posedge clock); #1;
    model(1, pr, pw, pa, pd);
    rd0 = r; wr0 = wr; ad0 = a; wd0 = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst2 = 1; rst0 = 1;
    rd2 = 0; wr2 = 0; ad2 = 0; wd2 = 0;
    rd0 = 0; wr0 = 0; ad0 = 0; wd0 = 0;
    reset_model(0);
    reset_model(1);
    repeat (2) @(posedge clock);
    #1 rst2 = 0; rst0 = 0;
    fork
      sweep(0, c2);
      sweep(1, c0);
    join
    check("init_sweep_l2", c2, 256);
    check("init_sweep_l0", c0, 16);
    en2 = 1; en0 = 1;

    // garbage, then a one-cycle reset pulse
    acc2(4'b0000, 3'b110, 32'h0, 32'hA5A5_A5A5);
    acc2(4'b0000, 3'b110, 32'h3FC, 32'h5A5A_5A5A);
    idle2();
    check("garbage_debug", dbg2, 32'hA5A5_A5A5);
    @(posedge clock); #1 en2 = 0; rst2 = 1;
    @(posedge clock); #1 rst2 = 0;
    sweep(0, c2);
    check("pulse_sweep_len", c2, 256);
    reset_model(0);
    en2 = 1;
    check("sweep_debug_zero", dbg2, 32'h0);
    acc2(4'b1010, 3'b000, 32'h3FC, 32'h0);
    check("lw_3fc_zero", q2, 32'h0);

    // sub-word stores
    acc2(4'b0000, 3'b110, 32'h10, 32'h8899_AABB);
    acc2(4'b0000, 3'b100, 32'h12, 32'h0000_0011);
    acc2(4'b0000, 3'b101, 32'h14, 32'h0000_2233);
    acc2(4'b1010, 3'b000, 32'h10, 32'h0);
    check("lw_10", q2, 32'h8811_AABB);
    acc2(4'b1010, 3'b000, 32'h14, 32'h0);
    check("lw_14", q2, 32'h0000_2233);
    idle2();

    // sign / zero extension
    acc2(4'b0000, 3'b110, 32'h20, 32'h80FF_7F01);
    acc2(4'b1000, 3'b000, 32'h22, 32'h0);
    check("lb_22", q2, 32'hFFFF_FFFF);
    acc2(4'b1100, 3'b000, 32'h22, 32'h0);
    check("lbu_22", q2, 32'h0000_00FF);
    acc2(4'b1000, 3'b000, 32'h20, 32'h0);
    check("lb_20", q2, 32'h0000_0001);
    acc2(4'b1001, 3'b000, 32'h22, 32'h0);
    check("lh_22", q2, 32'hFFFF_80FF);
    acc2(4'b1101, 3'b000, 32'h22, 32'h0);
    check("lhu_22", q2, 32'h0000_80FF);

    // misaligned and reserved encodings
    acc2(4'b0000, 3'b110, 32'h21, 32'hDEAD_BEEF);
    check("sw_21_mis", 32'(mis2), 32'd1);
    acc2(4'b1001, 3'b000, 32'h23, 32'h0);
    check("lh_23_data", q2, 32'h0);
    check("lh_23_mis", 32'(mis2), 32'd1);
    acc2(4'b1010, 3'b000, 32'h20, 32'h0);
    check("lw_20_after_mis", q2, 32'h80FF_7F01);
    check("lw_20_mis_clear", 32'(mis2), 32'd0);
    acc2(4'b0000, 3'b111, 32'h20, 32'h1111_1111);
    acc2(4'b1011, 3'b000, 32'h20, 32'h0);
    check("reserved_load", q2, 32'h0);
    acc2(4'b1010, 3'b000, 32'h20, 32'h0);
    check("size11_nochange", q2, 32'h80FF_7F01);

    // address wrap onto word 0
    acc2(4'b0000, 3'b110, 32'h400, 32'hCAFE_F00D);
    idle2();
    check("wrap_debug", dbg2, 32'hCAFE_F00D);

    // read and write together: no stall, no change
    @(posedge clock); #1;
    rd2 = 4'b1010; wr2 = 3'b110; ad2 = 32'h0; wd2 = 32'h1111_1111;
    repeat (3) @(posedge clock);
    #1 rd2 = 0; wr2 = 0;
    acc2(4'b1010, 3'b000, 32'h0, 32'h0);
    check("both_high_nochange", q2, 32'hCAFE_F00D);

    // reset in the WAIT cycle of a store, with misaligned set beforehand
    acc2(4'b1001, 3'b000, 32'h23, 32'h0);
    @(posedge clock); #1;
    rd2 = 0; wr2 = 3'b110; ad2 = 32'h30; wd2 = 32'h1234_5678; e2_busy = 1'b1;
    @(posedge clock); #1 en2 = 0; rst2 = 1;
    @(posedge clock); #1 rst2 = 0; rd2 = 0; wr2 = 0;
    sweep(0, c2);
    check("wait_reset_sweep", c2, 256);
    reset_model(0);
    en2 = 1;
    acc2(4'b1010, 3'b000, 32'h30, 32'h0);
    check("lw_30_discarded", q2, 32'h0);
    idle2();

    // LATENCY=0 back-to-back
    step0(4'b0, 3'b0, 32'h0, 32'h0, 4'b0000, 3'b110, 32'h8, 32'h0102_0304);
    step0(4'b0000, 3'b110, 32'h8, 32'h0102_0304, 4'b1010, 3'b000, 32'h8, 32'h0);
    step0(4'b1010, 3'b000, 32'h8, 32'h0, 4'b1000, 3'b000, 32'hB, 32'h0);
    check("l0_lw_8", q0, 32'h0102_0304);
    step0(4'b1000, 3'b000, 32'hB, 32'h0, 4'b1010, 3'b000, 32'h48, 32'h0);
    check("l0_lb_b", q0, 32'h0000_0001);
    step0(4'b1010, 3'b000, 32'h48, 32'h0, 4'b0000, 3'b100, 32'h40, 32'h77);
    check("l0_lw_wrap", q0, 32'h0102_0304);
    step0(4'b0000, 3'b100, 32'h40, 32'h77, 4'b0000, 3'b000, 32'h0, 32'h0);
    check("l0_sb_debug", dbg0, 32'h0000_0077);
    check("l0_no_stall", 32'(bw0), 32'd0);

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
